// File: rtl/bus_arb_pkg.sv
// Shared types and helpers for the bus generator arbiter.
package bus_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    PUSH = 2'd2
  } state_t;

  localparam int ID_W      = 8;
  // Widest packet the header helper accepts; packets are zero-extended to it.
  localparam int MAX_PKT_W = 256;

  // Destination ID lives in the top ID_W bits of a pkt_w-wide packet.
  function automatic logic [ID_W-1:0] dest_of(input logic [MAX_PKT_W-1:0] pkt,
                                              input int pkt_w);
    return ID_W'(pkt >> (pkt_w - ID_W));
  endfunction

endpackage

// File: rtl/bus_channel_arbiter.sv
// One bus: round-robin grant over the driver FIFOs, pop the winner's head
// packet, then push it to the addressed driver(s).
module bus_channel_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng  [drvrs-1:0],
  input  logic [pckg_sz-1:0] D_pop  [drvrs-1:0],
  output logic               pop    [drvrs-1:0],
  output logic               push   [drvrs-1:0],
  output logic [pckg_sz-1:0] D_push [drvrs-1:0]
);

  localparam int IDX_W = (drvrs > 1) ? $clog2(drvrs) : 1;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [IDX_W-1:0]   r_src;
  logic [pckg_sz-1:0] r_pkt;
  logic [pckg_sz-1:0] r_dpush;
  logic [drvrs-1:0]   r_pop;
  logic [drvrs-1:0]   r_push;

  logic [drvrs-1:0]   w_pnd;
  logic               w_any;
  logic [IDX_W-1:0]   w_grant;
  logic [IDX_W:0]     w_sum;
  logic [IDX_W-1:0]   w_idx;
  logic [drvrs-1:0]   w_grant_oh;
  logic [IDX_W-1:0]   w_next_ptr;
  logic [ID_W-1:0]    w_dest;
  logic [drvrs-1:0]   w_push_mask;

  // Gather pending flags into a vector and drive the per-driver outputs.
  always_comb begin
    for (int i = 0; i < drvrs; i++) begin
      w_pnd[i]  = pndng[i];
      pop[i]    = r_pop[i];
      push[i]   = r_push[i];
      D_push[i] = r_dpush;
    end
  end

  // Round-robin search: first pending driver starting at the pointer.
  always_comb begin
    w_any   = 1'b0;
    w_grant = '0;
    w_sum   = '0;
    w_idx   = '0;
    for (int i = 0; i < drvrs; i++) begin
      w_sum = {1'b0, r_ptr} + (IDX_W+1)'(i);
      if (w_sum >= (IDX_W+1)'(drvrs)) begin
        w_sum = w_sum - (IDX_W+1)'(drvrs);
      end
      w_idx = w_sum[IDX_W-1:0];
      if (!w_any && w_pnd[w_idx]) begin
        w_any   = 1'b1;
        w_grant = w_idx;
      end
    end
    w_grant_oh          = '0;
    w_grant_oh[w_grant] = 1'b1;
    w_next_ptr = (w_grant == IDX_W'(drvrs - 1)) ? '0 : w_grant + IDX_W'(1);
  end

  // Destination decode: unicast (self included), broadcast to all but the
  // source, anything else is dropped.
  always_comb begin
    w_dest      = dest_of(MAX_PKT_W'(r_pkt), pckg_sz);
    w_push_mask = '0;
    if (int'(w_dest) < drvrs) begin
      w_push_mask[w_dest[IDX_W-1:0]] = 1'b1;
    end else if (w_dest == broadcast) begin
      w_push_mask        = '1;
      w_push_mask[r_src] = 1'b0;
    end
  end

  // Capture the granted driver's head word; qualified by the grant, so no reset needed.
  always_ff @(posedge clk) begin
    if (r_state == IDLE && w_any) begin
      r_pkt <= D_pop[w_grant];
    end
  end

  // Transaction FSM with registered pop/push strobes and delivered data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_src   <= '0;
      r_pop   <= '0;
      r_push  <= '0;
      r_dpush <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_push <= '0;
          if (w_any) begin
            r_src   <= w_grant;
            r_ptr   <= w_next_ptr;
            r_pop   <= w_grant_oh;
            r_state <= POP;
          end
        end
        POP: begin
          r_pop   <= '0;
          r_push  <= w_push_mask;
          r_dpush <= r_pkt;
          r_state <= PUSH;
        end
        PUSH: begin
          r_push  <= '0;
          r_state <= IDLE;
        end
        default: begin
          r_pop   <= '0;
          r_push  <= '0;
          r_state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: rtl/bus_generator_arbiter.sv
// Shared-bus emulator: one independent channel arbiter per bus.
module bus_generator_arbiter
  import bus_arb_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pndng  [bits-1:0][drvrs-1:0],
  input  logic [pckg_sz-1:0] D_pop  [bits-1:0][drvrs-1:0],
  output logic               pop    [bits-1:0][drvrs-1:0],
  output logic               push   [bits-1:0][drvrs-1:0],
  output logic [pckg_sz-1:0] D_push [bits-1:0][drvrs-1:0]
);

  for (genvar b = 0; b < bits; b++) begin : g_bus
    bus_channel_arbiter #(
      .drvrs    (drvrs),
      .pckg_sz  (pckg_sz),
      .broadcast(broadcast)
    ) u_channel (
      .clk   (clk),
      .reset (reset),
      .pndng (pndng[b]),
      .D_pop (D_pop[b]),
      .pop   (pop[b]),
      .push  (push[b]),
      .D_push(D_push[b])
    );
  end

endmodule

// File: tb/tb_bus_generator_arbiter.sv
// Scoreboard bench for bus_generator_arbiter: driver FIFOs are modelled in
// the bench, expected pop/push events are queued by the stimulus and
// compared by an independent monitor.
module tb_bus_generator_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        pndng  [0:0][3:0] = '{default: '0};
  logic [15:0] D_pop  [0:0][3:0] = '{default: '0};
  logic        pop    [0:0][3:0];
  logic        push   [0:0][3:0];
  logic [15:0] D_push [0:0][3:0];

  always #5 clk = ~clk;

  bus_generator_arbiter #(
    .bits(1), .drvrs(4), .pckg_sz(16), .broadcast(8'hFF)
  ) dut (
    .clk(clk), .reset(reset), .pndng(pndng), .D_pop(D_pop),
    .pop(pop), .push(push), .D_push(D_push)
  );

  typedef struct {
    bit          kind;   // 0 = pop, 1 = push
    logic [3:0]  mask;
    logic [15:0] data;
    int          cyc;
  } ev_t;

  typedef struct {
    int          drv;
    logic [15:0] data;
  } ld_t;

  ev_t         exp_q [$];
  ld_t         load_q [$];
  logic [15:0] fifo [4][$];
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;
  logic [3:0]  pm, um;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, want %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic add_pop(logic [3:0] mask, int c);
    ev_t e;
    e.kind = 1'b0; e.mask = mask; e.data = 16'h0; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic add_push(logic [3:0] mask, logic [15:0] data, int c);
    ev_t e;
    e.kind = 1'b1; e.mask = mask; e.data = data; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic load(int d, logic [15:0] data);
    ld_t l;
    l.drv = d; l.data = data;
    load_q.push_back(l);
  endtask

  task automatic check_ev(bit kind, logic [3:0] mask);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_checks++;
      $display("FAIL unexpected_%s: got mask %b at cycle %0d, want none",
               kind ? "push" : "pop", mask, cyc);
      return;
    end
    e = exp_q.pop_front();
    chk(kind ? "event_kind_push" : "event_kind_pop", 32'(kind), 32'(e.kind));
    chk(kind ? "push_mask" : "pop_mask", 32'(mask), 32'(e.mask));
    chk(kind ? "push_cycle" : "pop_cycle", cyc, e.cyc);
    if (kind) begin
      for (int j = 0; j < 4; j++) chk("D_push_data", 32'(D_push[0][j]), 32'(e.data));
    end
  endtask

  // Driver FIFO model: honour pops, accept loads, present head word.
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) begin
      if (pop[0][d] === 1'b1 && fifo[d].size() > 0) void'(fifo[d].pop_front());
    end
    while (load_q.size() > 0) begin
      ld_t l;
      l = load_q.pop_front();
      fifo[l.drv].push_back(l.data);
    end
    for (int d = 0; d < 4; d++) begin
      pndng[0][d] = (fifo[d].size() > 0);
      D_pop[0][d] = (fifo[d].size() > 0) ? fifo[d][0] : 16'h0;
    end
  end

  // Monitor: every observed pop or push is matched against the scoreboard.
  always @(negedge clk) begin
    for (int j = 0; j < 4; j++) begin
      pm[j] = pop[0][j];
      um[j] = push[0][j];
    end
    if (pm !== 4'b0000) check_ev(1'b0, pm);
    if (um !== 4'b0000) check_ev(1'b1, um);
  end

  task automatic wait_drain(string name, int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else begin
      $display("FAIL drain_%s: got %0d events outstanding, want 0", name, exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  task automatic check_idle_outputs(string name);
    for (int d = 0; d < 4; d++) begin
      chk({name, "_pop"}, 32'(pop[0][d]), 32'h0);
      chk({name, "_push"}, 32'(push[0][d]), 32'h0);
      chk({name, "_D_push"}, 32'(D_push[0][d]), 32'h0);
    end
  endtask

  localparam logic [15:0] RR_DATA [8] = '{16'h0100, 16'h0210, 16'h0320, 16'h0030,
                                          16'h0101, 16'h0211, 16'h0321, 16'h0031};
  localparam logic [3:0]  RR_PUSH [8] = '{4'b0010, 4'b0100, 4'b1000, 4'b0001,
                                          4'b0010, 4'b0100, 4'b1000, 4'b0001};

  initial begin
    int c;
    reset = 1'b0;

    // Reset held with a packet pending: nothing may be granted.
    repeat (2) @(posedge clk);
    #2 load(0, 16'h02AB);
    repeat (4) @(posedge clk);
    #2 check_idle_outputs("reset_hold");
    chk("reset_no_grant_pndng", 32'(pndng[0][0]), 32'h1);

    // Release: the pending unicast to driver 2 goes through.
    reset = 1'b1;
    c = cyc;
    add_pop(4'b0001, c + 1);
    add_push(4'b0100, 16'h02AB, c + 2);
    wait_drain("unicast", 20);
    chk("D_push_hold", 32'(D_push[0][3]), 32'h02AB);

    // Broadcast from driver 1.
    @(posedge clk);
    #2 c = cyc;
    load(1, 16'hFF5A);
    add_pop(4'b0010, c + 1);
    add_push(4'b1101, 16'hFF5A, c + 2);
    wait_drain("broadcast", 20);

    // Invalid destination: popped, never pushed.
    @(posedge clk);
    #2 c = cyc;
    load(0, 16'hABBA);
    add_pop(4'b0001, c + 1);
    wait_drain("invalid", 20);
    repeat (3) @(posedge clk);
    chk("invalid_D_push_latched", 32'(D_push[0][1]), 32'hABBA);

    // Reset during POP: outputs clear at once, packet never delivered.
    @(posedge clk);
    #2 c = cyc;
    load(2, 16'h0177);
    add_pop(4'b0100, c + 1);
    @(negedge clk);
    @(negedge clk);
    #1 reset = 1'b0;
    #1 check_idle_outputs("reset_mid");
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;
    c = cyc;
    load(0, 16'h03C0);
    load(3, 16'h00C3);
    add_pop(4'b0001, c + 1);
    add_push(4'b1000, 16'h03C0, c + 2);
    add_pop(4'b1000, c + 4);
    add_push(4'b0001, 16'h00C3, c + 5);
    wait_drain("reset_mid", 30);

    // Round robin: all four drivers, two packets each.
    @(posedge clk);
    #2 c = cyc;
    for (int k = 0; k < 8; k++) load(k % 4, RR_DATA[k]);
    for (int k = 0; k < 8; k++) begin
      add_pop(4'(1 << (k % 4)), c + 1 + 3 * k);
      add_push(RR_PUSH[k], RR_DATA[k], c + 2 + 3 * k);
    end
    wait_drain("round_robin", 60);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
